// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {S_NORM, S_HPRI, S_LOCK} state_e;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_e;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating host wait counter with clear and reached-limit flag
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != LIM) ? cnt_q + WAIT_W'(1) : cnt_q;
    hit = cnt_d == LIM;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the CPU and a host loader
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_locked,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state_d, state_q;
  owner_e own_d, own_q;
  logic cpu_gnt, hit, rd_d, rd_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(host_req && !host_gnt),
    .clr(host_gnt),
    .hit(hit)
  );
  always_comb begin
    cpu_gnt = reset && cpu_req && (state_q == S_NORM || (state_q == S_HPRI && !host_req));
    host_gnt = reset && host_req && (state_q != S_NORM || !cpu_req);
    cpu_stall = reset && cpu_req && !cpu_gnt;
    mem_we = cpu_gnt ? cpu_we : host_gnt && host_we;
    addr_d = cpu_gnt ? cpu_addr : host_gnt ? host_addr : addr_q;
    wdata_d = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : wdata_q;
    mem_addr = addr_d;
    mem_wdata = wdata_d;
    rd_d = (cpu_gnt && !cpu_we) || (host_gnt && !host_we);
    own_d = host_gnt ? OWN_HOST : OWN_CPU;
    state_d = state_q == S_LOCK ? (host_lock ? S_LOCK : S_NORM) :
              (host_lock && !cpu_gnt) ? S_LOCK :
              (state_q == S_HPRI && host_gnt) ? S_NORM :
              (state_q == S_NORM && hit) ? S_HPRI : state_q;
    host_locked = state_q == S_LOCK;
    host_rvalid = rd_q && own_q == OWN_HOST;
    host_rdata = host_rvalid ? mem_rdata : '0;
    cpu_rdata = reset ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_NORM;
      own_q <= OWN_CPU;
      rd_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for the data-memory port arbiter
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;
  typedef struct {
    logic [31:0] data;
    int cyc;
  } rd_t;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
  logic cpu_stall, host_gnt, host_locked, host_rvalid, mem_we;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256] = '{default: 0};
  logic [31:0] shadow [256] = '{default: 0};
  logic [31:0] cpu_exp = 0;
  logic cpu_pend = 0;
  rd_t sb [$];
  int cyc = 0, n_chk = 0, n_err = 0;
  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_locked(host_locked),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (host_rvalid) begin
      rd_t e;
      if (sb.size() == 0) chk("spurious_rvalid", host_rvalid, 0);
      else begin
        e = sb.pop_front();
        chk("host_rdata", host_rdata, e.data);
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic step(input logic cr, cw, input logic [31:0] ca, cd,
                      input logic hr, hw, input logic [31:0] ha, hd,
                      input logic hl, eg_c, eg_h, el);
    rd_t e;
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    #1;
    if (cpu_pend) chk("cpu_rdata", cpu_rdata, cpu_exp);
    cpu_pend = 0;
    chk("cpu_stall", cpu_stall, cr & ~eg_c);
    chk("host_gnt", host_gnt, eg_h);
    chk("host_locked", host_locked, el);
    if (eg_c | eg_h) begin
      chk("mem_we", mem_we, eg_c ? cw : hw);
      chk("mem_addr", mem_addr, eg_c ? ca : ha);
      if (eg_c ? cw : hw) chk("mem_wdata", mem_wdata, eg_c ? cd : hd);
    end else chk("mem_we_idle", mem_we, 0);
    if (eg_c) begin
      if (cw) shadow[ca[9:2]] = cd;
      else begin
        cpu_exp = shadow[ca[9:2]];
        cpu_pend = 1;
      end
    end
    if (eg_h) begin
      if (hw) shadow[ha[9:2]] = hd;
      else begin
        e.data = shadow[ha[9:2]];
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic hwr(input logic [31:0] a, d);
    step(0, 0, 0, 0, 1, 1, a, d, 0, 0, 1, 0);
  endtask
  task automatic hrd(input logic [31:0] a);
    step(0, 0, 0, 0, 1, 0, a, 0, 0, 0, 1, 0);
  endtask
  task automatic crd(input logic [31:0] a);
    step(1, 0, a, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_cpu_stall"}, cpu_stall, 0);
    chk({tag, "_host_gnt"}, host_gnt, 0);
    chk({tag, "_host_locked"}, host_locked, 0);
    chk({tag, "_host_rvalid"}, host_rvalid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_host_rdata"}, host_rdata, 0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(S_NORM));
    chk({tag, "_wait_cnt"}, 32'(dut.u_cnt.cnt_q), 0);
  endtask
  initial begin
    #1 reset = 0;
    host_req = 1; host_addr = 32'h10;
    repeat (2) @(negedge clk);
    #1 chk_zero("rst");
    host_req = 0;
    @(negedge clk) reset = 1;
    hrd(32'h10);
    @(posedge clk);
    #1 reset = 0;
    sb.delete();
    @(negedge clk);
    #1 chk_zero("rst_mid");
    host_req = 0;
    @(negedge clk) reset = 1;
    idle();
    idle();
    hwr(32'h20, 32'hDEADBEEF);
    hrd(32'h20);
    idle();
    repeat (4) step(1, 0, 32'h20, 0, 1, 1, 32'h44, 32'h5555, 0, 1, 0, 0);
    step(1, 0, 32'h20, 0, 1, 1, 32'h44, 32'h5555, 0, 0, 1, 0);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h40, 32'h1234, 1, 0, 32'h44, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1 chk("wait_cnt_inc", 32'(dut.u_cnt.cnt_q), 1);
    hrd(32'h40);
    hrd(32'h44);
    step(1, 0, 32'h08, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 32'h08, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 32'h08, 0, 1, 1, 32'(i * 4), 32'hC0DE0000 + 32'(i), i < 7, 0, 1, 1);
    step(1, 0, 32'h08, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    hwr(32'h08, 32'hAAAA0008);
    hwr(32'h0C, 32'hBBBB000C);
    repeat (2) begin
      crd(32'h08);
      hrd(32'h0C);
    end
    idle();
    idle();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipelined CPU and a host loader/reader.
- The host writes RSA keys and plaintext into the memory and reads results back.
- Sits between the CPU's memory interface and data_mem. It stalls the CPU whenever the host owns the port.
- Guarantees host progress with a starvation counter, and offers a host lock mode for bulk loads.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MAX_WAIT, 4, maximum consecutive denied host-request cycles before the host is forced priority (range 1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU memory access request (load or store) this cycle
- cpu_we  in  1  CPU store when 1, load when 0
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU must hold its memory stage this cycle
- cpu_rdata  out  DATA_W  CPU load data
- host_req  in  1  host access request; held with stable fields until granted
- host_we  in  1  host write when 1, read when 0
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_lock  in  1  host requests exclusive ownership
- host_gnt  out  1  host access accepted this cycle
- host_locked  out  1  lock is in effect; the CPU is fully paused
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after the address (synchronous read)

Behaviour:
- Reset (asynchronous, active-low):
  - While reset is low, the FSM is forced to S_NORM and wait_cnt=0.
  - All outputs are 0: cpu_stall, host_gnt, host_locked, host_rvalid, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata.
  - Any in-flight read response is discarded. No host_rvalid is issued after reset releases.
- FSM states: S_NORM (CPU priority), S_HPRI (host priority pending), S_LOCK (host exclusive).
- Grant is combinational from the current state and this cycle's requests.
  - S_NORM: CPU wins a conflict. The host is granted only if cpu_req=0.
  - S_HPRI: host wins a conflict.
  - S_LOCK: the host is granted whenever host_req=1. cpu_stall = cpu_req.
- cpu_stall = cpu_req & ~cpu_gnt. A stalled CPU access is retried the next cycle; no buffering is done in this block.
- Memory mux: the granted requester's we/addr/wdata drive mem_*. With no grant, mem_we=0 and addr/wdata hold their last value.
- wait_cnt (4 bit):
  - Increments each cycle host_req=1 and host_gnt=0; saturates at MAX_WAIT.
  - Clears on host_gnt.
- Transitions:
  - S_NORM→S_HPRI when wait_cnt reaches MAX_WAIT.
  - S_HPRI→S_NORM on the cycle after host_gnt.
  - Any state→S_LOCK when host_lock=1 and no CPU access is granted in that cycle.
  - S_LOCK→S_NORM when host_lock=0.
  - host_locked=1 exactly while in S_LOCK.
- Read return:
  - A 1-bit registered owner tag records who issued a read in the previous cycle.
  - cpu_rdata follows mem_rdata combinationally; the CPU samples it one cycle after its read is granted.
  - Host: host_rvalid=1 and host_rdata=mem_rdata (registered capture) exactly one cycle after the host read grant, for a single cycle. There is no backpressure; the host must accept.
- Write latency: a write is committed on the grant edge; host_rvalid is not asserted for writes.
- Simultaneous events:
  - host_lock rising while the CPU holds the grant: the lock waits until a cycle with no CPU grant.
  - host_lock falling while host_req=1: the final locked cycle still grants the host.
- Throughput: at most one access per cycle. Back-to-back host reads are allowed, giving a 1/cycle rvalid stream.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum for FSM states {S_NORM, S_HPRI, S_LOCK}
  - owner enum {OWN_CPU, OWN_HOST}
  - WAIT_W=4 constant
- One sub-module, arb_starve_counter: saturating wait counter with clear and a reached-limit output.
- Mux and FSM stay in the top of the block.

Test Plan:
- Reset low mid host read (host_req=1, host_we=0, addr=0x10) → all outputs 0, no host_rvalid after release, FSM in S_NORM.
- cpu_req=0, host writes 0xDEADBEEF to 0x20, then reads 0x20 → host_gnt both cycles; host_rvalid=1 with host_rdata=0xDEADBEEF exactly 1 cycle after the read grant.
- cpu_req held 1 continuously, host_req=1, MAX_WAIT=4 → host denied 4 cycles, granted on cycle 5 with cpu_stall=1 that cycle; the CPU regains grant the following cycle.
- Both request in S_NORM, wait_cnt<MAX_WAIT → CPU store to 0x40 with data 0x1234 reaches memory, cpu_stall=0, host_gnt=0, wait_cnt increments.
- host_lock=1 while the CPU is granted → lock deferred until a cycle with no CPU grant; then host_locked=1, cpu_stall=cpu_req, 8 host writes to 0x00..0x1C at 1/cycle; lock drops → CPU resumes the next cycle.
- Alternating CPU read (0x08) and host read (0x0C) grants → cpu_rdata and host_rdata each carry their own address's data; no cross-delivery.
